// File: rtl/imm_pkg.sv
// Shared types and encodings for the RISC-V immediate decode pipeline.
// Holds the format code enum, base opcode constants, compressed
// quadrant/funct3 constants and the stage-1 payload struct.
package imm_pkg;

    localparam int unsigned INSN_W = 32;
    localparam int unsigned FMT_W  = 4;

    // Format code presented on out_fmt
    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 4'd0,
        FMT_I    = 4'd1,
        FMT_S    = 4'd2,
        FMT_B    = 4'd3,
        FMT_U    = 4'd4,
        FMT_J    = 4'd5,
        FMT_CI   = 4'd6,
        FMT_CB   = 4'd7,
        FMT_CJ   = 4'd8
    } fmt_e;

    // Base (32-bit) major opcodes, insn[6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Quadrant field insn[1:0]; 11 marks a full-width word
    localparam logic [1:0] QUAD_C1   = 2'b01;
    localparam logic [1:0] QUAD_BASE = 2'b11;

    // Quadrant-1 funct3 values, insn[15:13]
    localparam logic [2:0] C1_F3_ADDI     = 3'b000;
    localparam logic [2:0] C1_F3_JAL_ADDIW = 3'b001;
    localparam logic [2:0] C1_F3_LI       = 3'b010;
    localparam logic [2:0] C1_F3_J        = 3'b101;
    localparam logic [2:0] C1_F3_BEQZ     = 3'b110;
    localparam logic [2:0] C1_F3_BNEZ     = 3'b111;

    // Stage-1 payload: raw word plus the classification made at accept time
    typedef struct packed {
        logic [INSN_W-1:0] insn;
        fmt_e              fmt;
        logic              compressed;
        logic              illegal;
    } s1_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor.
// Ports:
//   insn - raw instruction word (compressed words in [15:0])
//   fmt  - format already chosen by the classifier
//   imm  - immediate sign-extended from its top encoded bit to XLEN
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSN_W-1:0] insn,
    input  fmt_e              fmt,
    output logic [XLEN-1:0]   imm
);

    // Quadrant bits carry no immediate payload in any format
    logic unused_quad;
    assign unused_quad = ^insn[1:0];

    // Each field is gathered into a signed vector so the XLEN cast sign-extends
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:  imm = XLEN'($signed(insn[31:20]));
            FMT_S:  imm = XLEN'($signed({insn[31:25], insn[11:7]}));
            FMT_B:  imm = XLEN'($signed({insn[31], insn[7], insn[30:25],
                                         insn[11:8], 1'b0}));
            FMT_U:  imm = XLEN'($signed({insn[31:12], 12'h000}));
            FMT_J:  imm = XLEN'($signed({insn[31], insn[19:12], insn[20],
                                         insn[30:21], 1'b0}));
            FMT_CI: imm = XLEN'($signed({insn[12], insn[6:2]}));
            // offset[11|4|9:8|10|6|7|3:1|5] = insn[12:2]
            FMT_CJ: imm = XLEN'($signed({insn[12], insn[8], insn[10:9],
                                         insn[6], insn[7], insn[2],
                                         insn[11], insn[5:3], 1'b0}));
            // offset[8|4:3] = insn[12|11:10], offset[7:6|2:1|5] = insn[6:5|4:3|2]
            FMT_CB: imm = XLEN'($signed({insn[12], insn[6:5], insn[2],
                                         insn[11:10], insn[4:3], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// Two-stage RISC-V immediate decode pipeline between fetch and register read.
// Stage 1 latches the word and its format; stage 2 holds the extracted
// immediate and flags. Valid/ready on both sides, with ready propagating
// combinationally back through both stages.
// Ports:
//   clk, resetn            - clock, async active-low reset
//   flush                  - drops everything in flight at the next edge
//   in_valid/in_ready      - input handshake, in_insn is the raw word
//   out_valid/out_ready    - output handshake
//   out_imm                - XLEN sign-extended immediate
//   out_fmt                - format code (fmt_e)
//   out_compressed         - source word was 16-bit
//   out_illegal            - word not decodable under RVC/XLEN
//   illegal_cnt            - saturating count of illegal results handed off
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RVC   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INSN_W-1:0] in_insn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [FMT_W-1:0]  out_fmt,
    output logic              out_compressed,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    logic            s1_valid;
    logic            s2_valid;
    s1_t             s1_q;
    logic            s1_adv;
    logic            s2_adv;
    logic            in_fire;
    logic            out_fire;
    fmt_e            cls_fmt;
    logic            cls_comp;
    logic            cls_ill;
    logic [XLEN-1:0] s1_imm;

    // Format classifier on the incoming word
    always_comb begin
        cls_fmt  = FMT_NONE;
        cls_comp = (in_insn[1:0] != QUAD_BASE);
        cls_ill  = 1'b0;
        if (!cls_comp) begin
            case (in_insn[6:0])
                OP_LOAD, OP_IMM, OP_JALR: cls_fmt = FMT_I;
                OP_STORE:                 cls_fmt = FMT_S;
                OP_BRANCH:                cls_fmt = FMT_B;
                OP_LUI, OP_AUIPC:         cls_fmt = FMT_U;
                OP_JAL:                   cls_fmt = FMT_J;
                default:                  cls_fmt = FMT_NONE;
            endcase
        end else if (RVC == 0) begin
            cls_ill = 1'b1;
        end else if (in_insn[1:0] == QUAD_C1) begin
            case (in_insn[15:13])
                C1_F3_ADDI, C1_F3_LI: cls_fmt = FMT_CI;
                // c.jal on RV32, c.addiw on RV64
                C1_F3_JAL_ADDIW:      cls_fmt = (XLEN == 32) ? FMT_CJ : FMT_CI;
                C1_F3_J:              cls_fmt = FMT_CJ;
                C1_F3_BEQZ, C1_F3_BNEZ: cls_fmt = FMT_CB;
                default:              cls_fmt = FMT_NONE;
            endcase
        end
    end

    // Handshake: ready ripples back through both stages in the same cycle
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // Stage 1: raw word and classification
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_q.insn       <= in_insn;
                s1_q.fmt        <= cls_fmt;
                s1_q.compressed <= cls_comp;
                s1_q.illegal    <= cls_ill;
            end
        end
    end

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .insn (s1_q.insn),
        .fmt  (s1_q.fmt),
        .imm  (s1_imm)
    );

    // Stage 2: output registers, held while stalled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid       <= 1'b0;
            out_imm        <= '0;
            out_fmt        <= FMT_NONE;
            out_compressed <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_imm        <= s1_imm;
                out_fmt        <= s1_q.fmt;
                out_compressed <= s1_q.compressed;
                out_illegal    <= s1_q.illegal;
            end
        end
    end

    // Saturating count of illegal results handed to the consumer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            illegal_cnt <= '0;
        end else if (out_fire && out_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: three instances (RV32+RVC, RV64+RVC,
// RV32 without RVC and a 2-bit counter) share one input stream; an
// arithmetic reference decoder and an in-flight queue predict outputs.
module tb_imm_decode_pipe;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_insn;
    logic        out_ready;

    logic        a_in_ready, b_in_ready, c_in_ready;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic [31:0] a_out_imm, c_out_imm;
    logic [63:0] b_out_imm;
    logic [3:0]  a_out_fmt, b_out_fmt, c_out_fmt;
    logic        a_out_comp, b_out_comp, c_out_comp;
    logic        a_out_ill, b_out_ill, c_out_ill;
    logic [15:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    imm_decode_pipe #(.XLEN(32), .RVC(1), .CNT_W(16)) u_a (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_insn(in_insn),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_fmt(a_out_fmt), .out_compressed(a_out_comp), .out_illegal(a_out_ill),
        .illegal_cnt(a_cnt));

    imm_decode_pipe #(.XLEN(64), .RVC(1), .CNT_W(16)) u_b (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_insn(in_insn),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_fmt(b_out_fmt), .out_compressed(b_out_comp), .out_illegal(b_out_ill),
        .illegal_cnt(b_cnt));

    imm_decode_pipe #(.XLEN(32), .RVC(0), .CNT_W(2)) u_c (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_insn(in_insn),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_imm(c_out_imm),
        .out_fmt(c_out_fmt), .out_compressed(c_out_comp), .out_illegal(c_out_ill),
        .illegal_cnt(c_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] q_insn[$];
    int          q_acc[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          out_cnt = 0;
    int          m_cnt_a = 0, m_cnt_b = 0, m_cnt_c = 0;
    logic [63:0] last_a_imm, last_b_imm;
    logic [3:0]  last_a_fmt, last_b_fmt;
    logic        last_a_comp, last_c_ill;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
        longint x;
        x = longint'({32'd0, w});
        return (x >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    function automatic longint sx(input longint v, input int width);
        if (v >= (longint'(1) << (width - 1))) return v - (longint'(1) << width);
        return v;
    endfunction

    // Reference decode straight from the encoding tables, by arithmetic
    task automatic ref_dec(input logic [31:0] w, input int xlen, input bit rvc,
                           output logic [63:0] imm, output int fmt,
                           output bit comp, output bit ill);
        longint v;
        longint op;
        longint f3;
        v    = 0;
        fmt  = 0;
        ill  = 0;
        comp = (fld(w, 1, 0) != 3);
        if (!comp) begin
            op = fld(w, 6, 0);
            if (op == 'h03 || op == 'h13 || op == 'h67) fmt = 1;
            else if (op == 'h23) fmt = 2;
            else if (op == 'h63) fmt = 3;
            else if (op == 'h37 || op == 'h17) fmt = 4;
            else if (op == 'h6F) fmt = 5;
        end else if (!rvc) begin
            ill = 1;
        end else if (fld(w, 1, 0) == 1) begin
            f3 = fld(w, 15, 13);
            if (f3 == 0 || f3 == 2) fmt = 6;
            else if (f3 == 1) fmt = (xlen == 32) ? 8 : 6;
            else if (f3 == 5) fmt = 8;
            else if (f3 == 6 || f3 == 7) fmt = 7;
        end
        case (fmt)
            1: v = sx(fld(w, 31, 20), 12);
            2: v = sx(fld(w, 31, 25) * 32 + fld(w, 11, 7), 12);
            3: v = sx(fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048
                      + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2, 13);
            4: v = sx(fld(w, 31, 12) * 4096, 32);
            5: v = sx(fld(w, 31, 31) * (1 << 20) + fld(w, 19, 12) * 4096
                      + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2, 21);
            6: v = sx(fld(w, 12, 12) * 32 + fld(w, 6, 2), 6);
            8: v = sx(fld(w, 12, 12) * 2048 + fld(w, 11, 11) * 16 + fld(w, 10, 9) * 256
                      + fld(w, 8, 8) * 1024 + fld(w, 7, 7) * 64 + fld(w, 6, 6) * 128
                      + fld(w, 5, 3) * 2 + fld(w, 2, 2) * 32, 12);
            7: v = sx(fld(w, 12, 12) * 256 + fld(w, 11, 10) * 8 + fld(w, 6, 5) * 64
                      + fld(w, 4, 3) * 2 + fld(w, 2, 2) * 32, 9);
            default: v = 0;
        endcase
        imm = 64'(v);
        if (xlen == 32) imm[63:32] = 32'd0;
    endtask

    task automatic check_head(input logic [31:0] w);
        logic [63:0] ei;
        int          ef;
        bit          ec, el;
        ref_dec(w, 32, 1'b1, ei, ef, ec, el);
        check("a_imm", {32'd0, a_out_imm}, ei);
        check("a_fmt", a_out_fmt, ef);
        check("a_comp", a_out_comp, ec);
        check("a_ill", a_out_ill, el);
        ref_dec(w, 64, 1'b1, ei, ef, ec, el);
        check("b_imm", b_out_imm, ei);
        check("b_fmt", b_out_fmt, ef);
        check("b_comp", b_out_comp, ec);
        check("b_ill", b_out_ill, el);
        ref_dec(w, 32, 1'b0, ei, ef, ec, el);
        check("c_imm", {32'd0, c_out_imm}, ei);
        check("c_fmt", c_out_fmt, ef);
        check("c_comp", c_out_comp, ec);
        check("c_ill", c_out_ill, el);
    endtask

    // One clock: check outputs against the model, cross the edge, update model.
    // Entered and left just after a falling edge with inputs already driven.
    task automatic tick();
        bit          exp_v, exp_rdy, in_fire, out_fire;
        logic [63:0] ei;
        int          ef;
        bit          ec, el;
        #1;
        exp_v   = (q_insn.size() > 0) && (cyc >= q_acc[0] + 1);
        exp_rdy = !flush && ((q_insn.size() < 2) || out_ready);
        check("a_out_valid", a_out_valid, exp_v);
        check("b_out_valid", b_out_valid, exp_v);
        check("c_out_valid", c_out_valid, exp_v);
        check("a_in_ready", a_in_ready, exp_rdy);
        check("b_in_ready", b_in_ready, exp_rdy);
        check("c_in_ready", c_in_ready, exp_rdy);
        check("a_cnt", a_cnt, m_cnt_a);
        check("b_cnt", b_cnt, m_cnt_b);
        check("c_cnt", c_cnt, m_cnt_c);
        if (exp_v) check_head(q_insn[0]);
        in_fire  = in_valid && exp_rdy;
        out_fire = exp_v && out_ready;
        if (out_fire) begin
            last_a_imm  = {32'd0, a_out_imm};
            last_a_fmt  = a_out_fmt;
            last_a_comp = a_out_comp;
            last_b_imm  = b_out_imm;
            last_b_fmt  = b_out_fmt;
            last_c_ill  = c_out_ill;
        end
        @(posedge clk);
        cyc++;
        if (flush) begin
            q_insn.delete();
            q_acc.delete();
        end else begin
            if (out_fire) begin
                ref_dec(q_insn[0], 32, 1'b0, ei, ef, ec, el);
                if (el && m_cnt_c < 3) m_cnt_c++;
                void'(q_insn.pop_front());
                void'(q_acc.pop_front());
                out_cnt++;
            end
            if (in_fire) begin
                q_insn.push_back(in_insn);
                q_acc.push_back(cyc);
                acc_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset();
        #1;
        check("rst_a_valid", a_out_valid, 0);
        check("rst_b_valid", b_out_valid, 0);
        check("rst_c_valid", c_out_valid, 0);
        check("rst_a_imm", {32'd0, a_out_imm}, 0);
        check("rst_b_imm", b_out_imm, 0);
        check("rst_a_fmt", a_out_fmt, 0);
        check("rst_c_flags", {c_out_comp, c_out_ill}, 0);
        check("rst_a_flags", {a_out_comp, a_out_ill}, 0);
        check("rst_a_cnt", a_cnt, 0);
        check("rst_c_cnt", c_cnt, 0);
        check("rst_in_ready", {a_in_ready, b_in_ready, c_in_ready}, 3'b111);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        #2 resetn = 1'b0;
        check_reset();
        q_insn.delete();
        q_acc.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_cnt_c = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Single word through an empty pipe with the consumer always ready
    task automatic send(input logic [31:0] w);
        int a0, o0, ta, to;
        a0 = acc_cnt;
        o0 = out_cnt;
        ta = -1;
        to = -1;
        in_insn   = w;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ta < 0 && acc_cnt > a0) begin
                ta = i;
                in_valid = 1'b0;
            end
            if (out_cnt > o0) begin
                to = i;
                break;
            end
        end
        check("send_done", out_cnt - o0, 1);
        check("send_latency", to - ta, 2);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [6:0]  ops [8];
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        r = $urandom;
        case ($urandom_range(0, 3))
            0, 1: return {r[31:7], ops[$urandom_range(0, 7)]};
            2:    return {r[31:2], 2'b01};
            default: return r;
        endcase
    endfunction

    logic [31:0] words [4];

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_insn   = 32'd0;
        out_ready = 1'b0;
        @(negedge clk);
        check_reset();
        @(negedge clk);
        resetn = 1'b1;

        // Directed immediates
        send(32'h0080006F);
        check("jal_imm", last_a_imm, 64'h8);
        check("jal_fmt", last_a_fmt, 5);
        check("jal_comp", last_a_comp, 0);
        send(32'hFE000EE3);
        check("beq_imm", last_a_imm, 64'hFFFFFFFC);
        check("beq_fmt", last_a_fmt, 3);
        send(32'h0000BFFD);
        check("cj_imm", last_a_imm, 64'hFFFFFFFE);
        check("cj_fmt", last_a_fmt, 8);
        check("cj_comp", last_a_comp, 1);
        check("cj_c_ill", last_c_ill, 1);
        send(32'h800000B7);
        check("lui64_imm", last_b_imm, 64'hFFFFFFFF80000000);
        check("lui64_fmt", last_b_fmt, 4);
        send(32'h00002005);
        check("ci64_imm", last_b_imm, 64'h1);
        check("ci64_fmt", last_b_fmt, 6);
        check("cj32_fmt", last_a_fmt, 8);
        send(32'h00004501);
        check("c_cnt_three", c_cnt, 3);

        // Reset with words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_insn   = 32'h00000001;
        tick();
        in_insn = 32'h00A00093;
        tick();
        pulse_reset();

        // Backpressure: 6 stalled cycles, 4 words offered back-to-back
        words = '{32'h00100093, 32'hFFF00113, 32'h00000005, 32'h0080006F};
        begin
            int a0, o0;
            a0 = acc_cnt;
            o0 = out_cnt;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            for (int i = 0; i < 6; i++) begin
                in_insn = words[acc_cnt - a0];
                tick();
            end
            check("bp_accepted", acc_cnt - a0, 2);
            check("bp_in_ready", a_in_ready, 0);
            out_ready = 1'b1;
            for (int i = 0; i < 30 && (out_cnt - o0) < 4; i++) begin
                in_valid = (acc_cnt - a0) < 4;
                if (in_valid) in_insn = words[acc_cnt - a0];
                tick();
            end
            in_valid = 1'b0;
            check("bp_outputs", out_cnt - o0, 4);
        end

        // Flush with both stages full; the flush-cycle word is dropped
        begin
            int a0;
            a0 = acc_cnt;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            for (int i = 0; i < 10 && (acc_cnt - a0) < 2; i++) begin
                in_insn = (acc_cnt == a0) ? 32'h00C00093 : 32'h00000863;
                tick();
            end
            check("fl_filled", acc_cnt - a0, 2);
            flush   = 1'b1;
            in_insn = 32'h7FF00013;
            tick();
            flush    = 1'b0;
            in_valid = 1'b0;
            #1;
            check("fl_out_valid", a_out_valid, 0);
            check("fl_dropped", acc_cnt - a0, 2);
            @(negedge clk);
            send(32'h01400513);
        end

        // Counter saturation on the 2-bit instance
        pulse_reset();
        send(32'h00000001);
        send(32'h00002005);
        send(32'h0000BFFD);
        send(32'h0000C001);
        send(32'h00004501);
        check("c_cnt_sat", c_cnt, 3);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            flush     = ($urandom_range(0, 49) == 0);
            out_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_insn   = rand_insn();
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("drain_empty", q_insn.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Parametrised, pipelined RISC-V immediate extractor. It covers all base formats (I/S/B/U/J) and the common compressed formats (CI/CB/CJ), for XLEN 32 or 64. It sits between instruction fetch and the register-read stage. It takes one 32-bit instruction word per valid/ready handshake and returns the sign-extended immediate, the format code and an illegal flag two cycles later.

## Interface
- XLEN, 32, immediate output width; legal values 32 or 64.
- RVC, 1, 1 = decode compressed formats; 0 = any word with insn[1:0]!=2'b11 is illegal.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all in-flight entries.
- in_valid  in  1  in_insn is valid.
- in_ready  out  1  block accepts in_insn this cycle.
- in_insn  in  32  raw instruction word (compressed words occupy [15:0]).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  4  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, CI=6, CB=7, CJ=8.
- out_compressed  out  1  source word was 16-bit.
- out_illegal  out  1  format not decodable under the current parameters.
- illegal_cnt  out  CNT_W  saturating count of illegal results handed off.

## Operation
- Base opcode map: 0000011/0010011/1100111 → I; 0100011 → S; 1100011 → B; 0110111/0010111 → U; 1101111 → J.
- Any other base opcode → NONE with imm 0 and not illegal.
- U immediate: insn[31:12]<<12, sign-extended to XLEN.
- Compressed decode applies only when RVC=1, and only to quadrant 01:
  - funct3 000 or 010 → CI: imm = sext({insn[12], insn[6:2]}).
  - funct3 001 → CJ when XLEN=32, CI when XLEN=64.
  - funct3 101 → CJ: offset[11|4|9:8|10|6|7|3:1|5] = insn[12:2], offset[0]=0.
  - funct3 110 or 111 → CB: offset[8|4:3] = insn[12|11:10], offset[7:6|2:1|5] = insn[6:5|4:3|2], offset[0]=0.
- Other compressed encodings → NONE, not illegal.
- A compressed word with RVC=0 → out_illegal=1, fmt NONE, imm 0.
- Every immediate is sign-extended from its top encoded bit to XLEN. There is no truncation.
- illegal_cnt increments by 1 on each output handshake with out_illegal=1. It saturates at all-ones.

## Timing
- Two register stages. S1 latches in_insn and the decoded format. S2 holds out_imm, out_fmt and the flags.
- Latency is 2 cycles from input handshake to out_valid when not stalled. Throughput is 1 per cycle.
- s2_adv = !s2_valid || out_ready.
- s1_adv = !s1_valid || s2_adv.
- in_ready = s1_adv && !flush. This ready path is combinational through both stages, by design.
- Transfers happen only when valid && ready on the same edge.
- out_valid, once asserted, holds with stable data until out_ready is sampled high. The only exceptions are flush and reset.
- Flush: at the next edge, s1_valid and s2_valid clear. Input presented in the flush cycle is dropped. illegal_cnt is unaffected.
- Reset, at assertion and at any point mid-operation, sets:
  - out_valid, s1_valid = 0;
  - out_imm = 0, out_fmt = NONE;
  - out_compressed, out_illegal = 0;
  - illegal_cnt = 0.
- While resetn is low, in_ready reads 1 but no transfer occurs.
- Simultaneous out handshake and in handshake: both stages advance with no bubble.

## Structure
- Shared package imm_pkg holds the fmt_e enum, base opcode constants and compressed quadrant/funct3 constants.
- One sub-module, imm_extract: combinational (insn, fmt) → XLEN immediate, parametrised by XLEN.
- imm_decode_pipe contains the format classifier, both pipeline stages, the handshake logic and the counter.

## Test plan
- XLEN=32, in_insn 0x0080006F (jal x0,8) → two cycles later out_imm 0x00000008, out_fmt J=5, out_compressed 0.
- in_insn 0xFE000EE3 (beq x0,x0,-4) → out_imm 0xFFFFFFFC, fmt B=3. Then 0xBFFD (c.j -2) → out_imm 0xFFFFFFFE, fmt CJ=8, out_compressed 1.
- XLEN=64, in_insn 0x800000B7 (lui x1,0x80000) → out_imm 0xFFFFFFFF80000000, fmt U. Then 0x2005 → fmt CI=6, out_imm 1.
- Backpressure:
  - Stimulus: out_ready=0 for 6 cycles while 4 distinct words are offered back-to-back.
  - Required: exactly 2 words are accepted, then in_ready drops; out_valid and out_imm stay stable.
  - On release, all 4 results emerge in order with no loss and no duplicates.
- Flush with both stages full → out_valid 0 on the next cycle. The word offered in the flush cycle never appears. The next word emerges 2 cycles after acceptance.
- RVC=0: three compressed words, consumed → out_illegal 1 each and illegal_cnt=3. Then resetn pulsed low mid-stream → all outputs at reset values and illegal_cnt=0. With CNT_W=2, five illegal handshakes → illegal_cnt saturates at 3.
